main_mem_line_ctrl: RTL and testbench

//  Line-granular backing-store controller directly downstream of the data cache.

---
 rtl/mem_ctrl_pkg.sv | 21 ++
 rtl/mem_line_storage.sv | 36 +++
 rtl/main_mem_line_ctrl.sv | 122 ++++++++++++
 tb/tb_main_mem_line_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and line-geometry constants for the main-memory line controller
// and the data cache that sits in front of it.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2,
    RECOVER = 2'd3
  } mem_state_t;

  localparam int DEFAULT_LINE_SIZE = 128;
  localparam int LINE_BYTES        = DEFAULT_LINE_SIZE / 8;
  localparam int LINE_OFFSET_BITS  = $clog2(LINE_BYTES);

  // Number of byte-offset bits inside one line of the given width.
  function automatic int line_offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/mem_line_storage.sv
// Byte-addressable backing array with one full-line read port and one full-line
// write port; kept separate so it can be replaced by an SRAM macro.
module mem_line_storage #(
  parameter int LINE_BITS = 128,
  parameter int MEM_BYTES = 1024,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_wr_base,
  input  logic [LINE_BITS-1:0] i_wr_line,
  input  logic [AW-1:0]        i_rd_base,
  output logic [LINE_BITS-1:0] o_rd_line
);

  // Power-up image: byte i holds i[7:0]. Reset never touches the array.
  function automatic logic [MEM_BYTES*8-1:0] init_image();
    logic [MEM_BYTES*8-1:0] img;
    for (int i = 0; i < MEM_BYTES; i++) img[i*8 +: 8] = 8'(i);
    return img;
  endfunction

  logic [MEM_BYTES*8-1:0] r_mem = init_image();

  logic [AW+2:0] w_wr_bit;
  logic [AW+2:0] w_rd_bit;

  assign w_wr_bit  = {i_wr_base, 3'b000};
  assign w_rd_bit  = {i_rd_base, 3'b000};
  assign o_rd_line = r_mem[w_rd_bit +: LINE_BITS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[w_wr_bit +: LINE_BITS] <= i_wr_line;
  end

endmodule

// File: rtl/main_mem_line_ctrl.sv
// Line-granular backing-store controller serving cache line fills and dirty
// write-backs with a fixed access latency.
module main_mem_line_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_BYTES       = 1024,
  parameter int MEM_LATENCY     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_mem_read_en,
  input  logic                       in_mem_write_en,
  input  logic [31:0]                in_mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_read_data,
  output logic                       out_mem_ready,
  output logic                       out_mem_busy,
  output logic                       out_mem_wrap,
  output mem_state_t                 out_mem_state
);

  // Handshake: a request is a level on read_en/write_en that is sampled only in
  // IDLE; the requester holds it until the single-cycle ready pulse, and the
  // RECOVER cycle after it ignores inputs so a still-held level is not re-taken.

  localparam int LB = CACHE_LINE_SIZE / 8;
  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(MEM_LATENCY - 1);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LB - 1);

  mem_state_t                 r_state;
  logic [CW-1:0]              r_cnt;
  logic                       r_op_write;
  logic [AW-1:0]              r_base;
  logic [CACHE_LINE_SIZE-1:0] r_wdata;
  logic                       r_wrap_pend;
  logic                       r_ready;
  logic                       r_busy;
  logic                       r_wrap;
  logic [CACHE_LINE_SIZE-1:0] r_rdata;

  logic                       w_accept;
  logic [AW-1:0]              w_req_base;
  logic                       w_req_wrap;
  logic                       w_store_we;
  logic [CACHE_LINE_SIZE-1:0] w_rd_line;

  assign w_accept   = (r_state == IDLE) && (in_mem_read_en || in_mem_write_en);
  assign w_req_base = in_mem_addr[AW-1:0] & LINE_MASK;
  assign w_req_wrap = in_mem_addr >= 32'(MEM_BYTES);
  // The array only changes on the RESPOND edge, so a reset during WAIT leaves it intact.
  assign w_store_we = (r_state == RESPOND) && r_op_write && !reset;

  mem_line_storage #(
    .LINE_BITS (CACHE_LINE_SIZE),
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_storage (
    .clk       (clk),
    .i_we      (w_store_we),
    .i_wr_base (r_base),
    .i_wr_line (r_wdata),
    .i_rd_base (r_base),
    .o_rd_line (w_rd_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_write  <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_wrap_pend <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_ready <= 1'b0;
      r_wrap  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op_write  <= in_mem_write_en;
            r_base      <= w_req_base;
            r_wdata     <= in_mem_write_data;
            r_wrap_pend <= w_req_wrap;
            r_cnt       <= CW'(1);
            r_busy      <= 1'b1;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_CNT) r_state <= RESPOND;
        end
        RESPOND: begin
          r_ready <= 1'b1;
          r_wrap  <= r_wrap_pend;
          if (!r_op_write) r_rdata <= w_rd_line;
          r_state <= RECOVER;
        end
        RECOVER: begin
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_mem_read_data = r_rdata;
  assign out_mem_ready     = r_ready;
  assign out_mem_busy      = r_busy;
  assign out_mem_wrap      = r_wrap;
  assign out_mem_state     = r_state;

endmodule

// File: tb/tb_main_mem_line_ctrl.sv
// Bench for main_mem_line_ctrl: directed scenarios plus randomized traffic
// checked against a byte-array reference memory.
module tb_main_mem_line_ctrl;
  import mem_ctrl_pkg::*;

  localparam int LINE = 128;
  localparam int MB   = 1024;
  localparam int LAT  = 10;
  localparam int MAXW = 40;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_rd = 1'b0;
  logic            in_wr = 1'b0;
  logic [31:0]     in_addr = '0;
  logic [LINE-1:0] in_wdata = '0;
  logic [LINE-1:0] out_rdata;
  logic            out_ready;
  logic            out_busy;
  logic            out_wrap;
  mem_state_t      out_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]      ref_mem [MB];
  logic [LINE-1:0] last_read;
  logic [31:0]     exp_q[$];

  main_mem_line_ctrl #(
    .CACHE_LINE_SIZE (LINE),
    .MEM_BYTES       (MB),
    .MEM_LATENCY     (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_mem_read_en    (in_rd),
    .in_mem_write_en   (in_wr),
    .in_mem_addr       (in_addr),
    .in_mem_write_data (in_wdata),
    .out_mem_read_data (out_rdata),
    .out_mem_ready     (out_ready),
    .out_mem_busy      (out_busy),
    .out_mem_wrap      (out_wrap),
    .out_mem_state     (out_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_base(input logic [31:0] addr);
    return int'(addr % MB) & ~(LINE / 8 - 1);
  endfunction

  function automatic logic [LINE-1:0] ref_line(input logic [31:0] addr);
    logic [LINE-1:0] l;
    int b;
    b = ref_base(addr);
    for (int i = 0; i < LINE / 8; i++) l[i*8 +: 8] = ref_mem[b + i];
    return l;
  endfunction

  task automatic ref_write(input logic [31:0] addr, input logic [LINE-1:0] data);
    int b;
    b = ref_base(addr);
    for (int i = 0; i < LINE / 8; i++) ref_mem[b + i] = data[i*8 +: 8];
  endtask

  // ---------------- driver ----------------
  // Issues one request, holds it until ready (or drops it early), and reports
  // what was observed. lat = -1 means no ready pulse inside the wait budget.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [LINE-1:0] data, input bit drop_early,
                         output int lat, output logic [LINE-1:0] rdata,
                         output logic wrap, output logic busy_mid,
                         output logic pulse_short, output logic busy_after);
    @(negedge clk);
    in_rd = rd; in_wr = wr; in_addr = addr; in_wdata = data;
    @(posedge clk);
    lat = -1; rdata = '0; wrap = 1'b0; busy_mid = 1'b0;
    for (int k = 1; k <= MAXW; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy_mid = out_busy;
      if (drop_early && k == 2) begin
        in_rd = 1'b0; in_wr = 1'b0;
        in_addr = $urandom; in_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (out_ready) begin
        lat = k; rdata = out_rdata; wrap = out_wrap;
        break;
      end
    end
    in_rd = 1'b0; in_wr = 1'b0;
    @(posedge clk); #1;
    pulse_short = !out_ready;
    busy_after  = out_busy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (out_ready !== 1'b0 || out_busy !== 1'b0 || out_wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: ready=%b busy=%b wrap=%b required 0 0 0", out_ready, out_busy, out_wrap);
    end
    checks++;
    if (out_rdata !== '0) begin
      failures++;
      $display("FAIL reset_rdata: got %h required 0", out_rdata);
    end
    checks++;
    if (out_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d required %0d", out_state, IDLE);
    end
  endtask

  task automatic test_read_basic();
    int lat; logic [LINE-1:0] d; logic w, bm, ps, ba;
    logic [LINE-1:0] exp_line;
    exp_line = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    run_req(1'b1, 1'b0, 32'h100, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (lat !== LAT) begin
      failures++;
      $display("FAIL read_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (d !== exp_line || d !== ref_line(32'h100)) begin
      failures++;
      $display("FAIL read_0x100_data: got %h required %h", d, exp_line);
    end
    checks++;
    if (w !== 1'b0 || bm !== 1'b1 || ps !== 1'b1 || ba !== 1'b0) begin
      failures++;
      $display("FAIL read_0x100_ctrl: wrap=%b busy_mid=%b pulse_short=%b busy_after=%b required 0 1 1 0", w, bm, ps, ba);
    end
    last_read = d;
    run_req(1'b1, 1'b0, 32'h104, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (lat !== LAT || d !== exp_line) begin
      failures++;
      $display("FAIL read_0x104_offset: lat=%0d data=%h required %0d %h", lat, d, LAT, exp_line);
    end
    last_read = d;
  endtask

  task automatic test_write_read();
    int lat; logic [LINE-1:0] d; logic w, bm, ps, ba;
    logic [LINE-1:0] wd;
    wd = {4{32'hDDDDDDDD}};
    run_req(1'b0, 1'b1, 32'h200, wd, 1'b0, lat, d, w, bm, ps, ba);
    ref_write(32'h200, wd);
    checks++;
    if (lat !== LAT || d !== last_read || ba !== 1'b0) begin
      failures++;
      $display("FAIL write_0x200: lat=%0d held_data=%h busy_after=%b required %0d %h 0", lat, d, ba, LAT, last_read);
    end
    run_req(1'b1, 1'b0, 32'h200, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (d !== wd) begin
      failures++;
      $display("FAIL readback_0x200: got %h required %h", d, wd);
    end
    run_req(1'b1, 1'b0, 32'h210, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (d !== 128'h1F1E1D1C_1B1A1918_17161514_13121110) begin
      failures++;
      $display("FAIL read_0x210_untouched: got %h required 1f1e..1110", d);
    end
    last_read = d;
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_q[$];
    @(negedge clk);
    in_rd = 1'b1; in_wr = 1'b0; in_addr = 32'h120;
    @(posedge clk);
    for (int k = 1; k <= MAXW; k++) begin
      @(posedge clk); #1;
      if (out_ready) begin
        got_q.push_back(32'(k));
        checks++;
        if (out_rdata !== ref_line(32'h120)) begin
          failures++;
          $display("FAIL b2b_data: cycle %0d got %h required %h", k, out_rdata, ref_line(32'h120));
        end
      end
      if (k == 23) in_rd = 1'b0;
    end
    exp_q = {32'(LAT), 32'(2 * LAT + 2)};
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d completions required %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b_timing: completion %0d at %0d required %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    last_read = ref_line(32'h120);
  endtask

  task automatic test_both_enables();
    int lat; logic [LINE-1:0] d; logic w, bm, ps, ba;
    logic [LINE-1:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    run_req(1'b1, 1'b1, 32'h300, wd, 1'b0, lat, d, w, bm, ps, ba);
    ref_write(32'h300, wd);
    checks++;
    if (d !== last_read) begin
      failures++;
      $display("FAIL both_en_is_write: read_data changed to %h required held %h", d, last_read);
    end
    run_req(1'b1, 1'b0, 32'h300, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (d !== wd) begin
      failures++;
      $display("FAIL both_en_readback: got %h required %h", d, wd);
    end
    last_read = d;
  endtask

  task automatic test_random();
    int lat; logic [LINE-1:0] d; logic w, bm, ps, ba;
    logic [31:0] a; logic [LINE-1:0] wd; bit is_wr; bit drop;
    for (int n = 0; n < 30; n++) begin
      a     = 32'($urandom_range(0, 2 * MB - 1));
      wd    = {$urandom, $urandom, $urandom, $urandom};
      is_wr = bit'($urandom_range(0, 1));
      drop  = bit'($urandom_range(0, 1));
      run_req(!is_wr, is_wr, a, wd, drop, lat, d, w, bm, ps, ba);
      checks++;
      if (lat !== LAT || w !== (a >= MB) || ps !== 1'b1 || ba !== 1'b0) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: lat=%0d wrap=%b pulse_short=%b busy_after=%b required %0d %b 1 0",
                 n, lat, w, ps, ba, LAT, a >= MB);
      end
      if (is_wr) begin
        ref_write(a, wd);
        checks++;
        if (d !== last_read) begin
          failures++;
          $display("FAIL rand_write_hold[%0d]: got %h required %h", n, d, last_read);
        end
      end else begin
        checks++;
        if (d !== ref_line(a)) begin
          failures++;
          $display("FAIL rand_read[%0d] addr %h: got %h required %h", n, a, d, ref_line(a));
        end
        last_read = ref_line(a);
      end
    end
  endtask

  task automatic test_wrap_reset();
    int lat; logic [LINE-1:0] d; logic w, bm, ps, ba;
    int pulses;
    run_req(1'b1, 1'b0, 32'h400, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (d !== ref_line(32'h000) || w !== 1'b1) begin
      failures++;
      $display("FAIL wrap_0x400: data=%h wrap=%b required %h 1", d, w, ref_line(32'h000));
    end
    @(negedge clk);
    in_wr = 1'b1; in_addr = 32'h040; in_wdata = {4{32'hA5A5A5A5}};
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; in_wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_busy !== 1'b0 || out_ready !== 1'b0 || out_state !== IDLE) begin
      failures++;
      $display("FAIL reset_abort: busy=%b ready=%b state=%0d required 0 0 %0d", out_busy, out_ready, out_state, IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 2 * LAT; k++) begin
      @(posedge clk); #1;
      if (out_ready) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_no_ready: got %0d pulses required 0", pulses);
    end
    run_req(1'b1, 1'b0, 32'h040, '0, 1'b0, lat, d, w, bm, ps, ba);
    checks++;
    if (d !== ref_line(32'h040)) begin
      failures++;
      $display("FAIL aborted_write_untouched: got %h required %h", d, ref_line(32'h040));
    end
  endtask

  initial begin
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'(i);
    last_read = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_both_enables();
    test_random();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
